aer_word_assembler: RTL and testbench
=====================================

// Module: aer_word_assembler
// PURPOSE
//  Clocked consumer of the asynchronous AER bit decoder (X0), sitting directly downstream of it.
//  Synchronises the decoder's bit0/bit1/Dt outputs and returns senack to it (4-phase handshake).
//  Shifts decoded data symbols into an ADDR_W-bit event address and presents each complete
//  address on a valid/ready interface to the event-processing logic.
// PARAMETERS
//  ADDR_W    8    data bits per AER event address (>=1)
//  SYNC_FF   2    synchroniser depth on bit0/bit1/Dt (>=2)
//  TIMEOUT   255  max cycles in W_LOW waiting for Dt to fall before error abort (>=1)
// PORTS
//  clk         in   1       system clock; all state changes on rising edge
//  reset       in   1       synchronous, active-low reset
//  bit0        in   1       async symbol bit 0 from X0
//  bit1        in   1       async symbol bit 1 from X0
//  Dt          in   1       async symbol-valid strobe from X0
//  senack      out  1       symbol acknowledge back to X0
//  addr        out  ADDR_W  assembled event address, MSB received first
//  addr_valid  out  1       addr holds an unconsumed word
//  addr_ready  in   1       consumer accepts addr when addr_valid & addr_ready
//  frame_err   out  1       one-cycle pulse on framing error or timeout
// BEHAVIOUR
//  Reset (reset==0 at clk edge): senack=0, addr_valid=0, addr=0, frame_err=0,
//   state=IDLE, bit count=0, shift reg=0, timeout count=0, synchroniser flops=0.
//  Sync: bit0/bit1/Dt each pass SYNC_FF flops; *_s denotes synchronised values.
//  Symbol {bit1_s,bit0_s}: 01=data 0, 10=data 1, 11=end-of-word (EOW), 00=illegal.
//  FSM:
//   IDLE   : Dt_s==1 -> SAMPLE.
//   SAMPLE : one settle cycle; symbol latched at end of this cycle; -> EVAL.
//   EVAL   : data & count<ADDR_W -> shift in LSB side, count++, -> ACK.
//            EOW & count==ADDR_W -> if output slot free -> load addr, addr_valid=1, -> ACK;
//              else -> STALL.
//            data & count==ADDR_W, EOW & count<ADDR_W, or 00 -> frame_err pulse,
//              count=0, shift reg=0, -> ACK (symbol acked and discarded).
//   STALL  : senack held 0; when slot free -> load addr, addr_valid=1, -> ACK.
//   ACK    : senack=1; -> W_LOW.
//   W_LOW  : senack=1; Dt_s==0 -> senack=0, count cleared if word just emitted, -> IDLE.
//            timeout count hits TIMEOUT -> frame_err pulse, senack=0, count=0, -> IDLE.
//  Slot free: addr_valid==0, or addr_valid & addr_ready this cycle (same-cycle refill allowed).
//  addr_valid falls the cycle after handshake unless refilled in that same cycle.
//  addr stable while addr_valid==1 and addr_ready==0.
//  senack changes only from registered state (glitch-free); never high while state IDLE/SAMPLE/EVAL/STALL.
//  Latency: Dt edge to senack rise = SYNC_FF+3 cycles (no stall).
//  Last symbol is not acknowledged until the word is accepted into addr (back-pressure to X0).
//  Timeout counter active only in W_LOW; cleared on entry.
//  Reset mid-word: partial word discarded, senack drops on the reset edge.
// STRUCTURE
//  Package aer_pkg: symbol encodings (SYM_D0=2'b01, SYM_D1=2'b10, SYM_EOW=2'b11),
//   FSM state enum (IDLE,SAMPLE,EVAL,STALL,ACK,W_LOW).
//  Sub-module aer_sync (SYNC_FF-deep, 3-bit wide, synchronous active-low reset) for the inputs.
//  Remainder (FSM, shift register, counters, output register) in this module.
// TESTING
//  ADDR_W=8; send data 1,0,1,1,0,0,1,0 + EOW, addr_ready=1 -> addr=8'hB2, addr_valid 1 cycle, 9 senack pulses.
//  Same word, addr_ready=0 for 50 cycles -> senack for EOW withheld, addr_valid high, ack follows acceptance.
//  EOW after 3 data bits -> frame_err pulse, no addr_valid, next 8-bit word 8'h5A assembles correctly.
//  Symbol 00 mid-word -> frame_err pulse, count reset, senack still completes 4-phase cycle.
//  Dt held high 300 cycles (TIMEOUT=255) -> frame_err pulse, senack=0, FSM in IDLE.
//  reset=0 after 4 data bits -> senack=0, addr_valid=0 next edge; fresh 8-bit word decodes cleanly.

Source files
------------

// File: rtl/aer_pkg.sv
// Shared encodings for the AER word assembler: symbol codes and FSM states.
package aer_pkg;

    // Symbol codes as {bit1, bit0} from the asynchronous bit decoder.
    localparam logic [1:0] SYM_ILL = 2'b00;
    localparam logic [1:0] SYM_D0  = 2'b01;
    localparam logic [1:0] SYM_D1  = 2'b10;
    localparam logic [1:0] SYM_EOW = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        EVAL,
        STALL,
        ACK,
        W_LOW
    } state_t;

    // True for the two data-carrying symbol codes.
    function automatic logic sym_is_data(input logic [1:0] sym);
        return (sym == SYM_D0) || (sym == SYM_D1);
    endfunction

endpackage

// File: rtl/aer_sync.sv
// Multi-flop synchroniser for the three asynchronous decoder outputs.
module aer_sync #(
    parameter int SYNC_FF = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] din,
    output logic [2:0] dout
);

    logic [SYNC_FF-1:0][2:0] sync_p;

    // Shift the raw inputs through SYNC_FF flops; index 0 is the metastable stage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_FF-2:0], din};
        end
    end

    assign dout = sync_p[SYNC_FF-1];

endmodule

// File: rtl/aer_word_assembler.sv
// Assembles AER data symbols into event addresses, acknowledging each symbol
// back to the decoder with a 4-phase handshake and presenting finished words
// on a valid/ready interface.
module aer_word_assembler
    import aer_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int SYNC_FF = 2,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit0,
    input  logic              bit1,
    input  logic              Dt,
    output logic              senack,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(ADDR_W + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ADDR_W);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [2:0]        sync_out;
    logic              dt_s;
    logic [1:0]        sym_in_s;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        sym;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] shreg;
    logic [ADDR_W-1:0] shreg_shifted;
    logic [TMO_W-1:0]  tcnt;
    logic              word_done;

    logic              slot_free;
    logic              accepted;
    logic              shift_en;
    logic              load_en;
    logic              err;

    aer_sync #(
        .SYNC_FF (SYNC_FF)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   ({Dt, bit1, bit0}),
        .dout  (sync_out)
    );

    assign dt_s     = sync_out[2];
    assign sym_in_s = sync_out[1:0];

    // A pending word leaving this cycle frees the slot for a same-cycle refill.
    assign accepted  = addr_valid && addr_ready;
    assign slot_free = !addr_valid || addr_ready;

    // Next-state decode and datapath enables.
    always_comb begin
        state_nxt        = state;
        shift_en         = 1'b0;
        load_en          = 1'b0;
        err              = 1'b0;
        shreg_shifted    = shreg << 1;
        shreg_shifted[0] = (sym == SYM_D1);
        case (state)
            IDLE: begin
                if (dt_s) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                state_nxt = EVAL;
            end
            EVAL: begin
                if (sym_is_data(sym) && (cnt < CNT_FULL)) begin
                    shift_en  = 1'b1;
                    state_nxt = ACK;
                end else if ((sym == SYM_EOW) && (cnt == CNT_FULL)) begin
                    if (slot_free) begin
                        load_en   = 1'b1;
                        state_nxt = ACK;
                    end else begin
                        state_nxt = STALL;
                    end
                end else begin
                    err       = 1'b1;
                    state_nxt = ACK;
                end
            end
            STALL: begin
                if (slot_free) begin
                    load_en   = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                state_nxt = W_LOW;
            end
            W_LOW: begin
                if (!dt_s) begin
                    state_nxt = IDLE;
                end else if (tcnt == TMO_LAST) begin
                    err       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake outputs registered from the next state so senack never glitches.
    always_ff @(posedge clk) begin
        if (!reset) begin
            senack    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            senack    <= (state_nxt == ACK) || (state_nxt == W_LOW);
            frame_err <= err;
        end
    end

    // Symbol latch, bit counter, shift register and W_LOW timeout counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sym       <= SYM_ILL;
            cnt       <= '0;
            shreg     <= '0;
            tcnt      <= '0;
            word_done <= 1'b0;
        end else begin
            if (state == SAMPLE) sym <= sym_in_s;

            if (state != W_LOW) tcnt <= '0;
            else if (dt_s)      tcnt <= tcnt + 1'b1;

            if (err) begin
                cnt       <= '0;
                shreg     <= '0;
                word_done <= 1'b0;
            end else if (shift_en) begin
                cnt   <= cnt + 1'b1;
                shreg <= shreg_shifted;
            end else if (load_en) begin
                word_done <= 1'b1;
            end else if ((state == W_LOW) && !dt_s) begin
                // The word stays counted until its EOW handshake completes.
                if (word_done) begin
                    cnt   <= '0;
                    shreg <= '0;
                end
                word_done <= 1'b0;
            end
        end
    end

    // Output slot: load on completed word, drop valid once consumed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr       <= '0;
            addr_valid <= 1'b0;
        end else if (load_en) begin
            addr       <= shreg;
            addr_valid <= 1'b1;
        end else if (accepted) begin
            addr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aer_word_assembler.sv
// Self-checking bench for aer_word_assembler: an X0-style symbol driver, a
// queue-based word model, and a decoupled monitor that scores every accepted word.
module tb_aer_word_assembler;

    localparam int ADDR_W  = 8;
    localparam int SYNC_FF = 2;
    localparam int TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              reset;
    logic              bit0;
    logic              bit1;
    logic              Dt;
    logic              senack;
    logic [ADDR_W-1:0] addr;
    logic              addr_valid;
    logic              addr_ready;
    logic              frame_err;

    int tests = 0;
    int fails = 0;

    // Reference model state: expected words, received bits, expected errors.
    logic [ADDR_W-1:0] exp_q[$];
    int                mbits[$];
    int                fe_exp = 0;

    // Monitor observations.
    int                fe_seen = 0;
    int                ack_pulses = 0;
    int                valid_cycles = 0;
    int                ready_mode = 0;   // 0: always ready, 1: never ready, 2: random
    logic              senack_d = 1'b0;
    logic              prev_hold = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;

    aer_word_assembler #(
        .ADDR_W  (ADDR_W),
        .SYNC_FF (SYNC_FF),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bit0       (bit0),
        .bit1       (bit1),
        .Dt         (Dt),
        .senack     (senack),
        .addr       (addr),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Word-level model: bits accumulate MSB first; EOW with a full word emits it,
    // any other misuse is a framing error that discards the partial word.
    task automatic model_sym(input logic [1:0] s);
        logic [ADDR_W-1:0] w;
        if (s == 2'b01 || s == 2'b10) begin
            if (mbits.size() < ADDR_W) begin
                mbits.push_back((s == 2'b10) ? 1 : 0);
            end else begin
                fe_exp++;
                mbits.delete();
            end
        end else if (s == 2'b11 && mbits.size() == ADDR_W) begin
            w = '0;
            foreach (mbits[i]) w = {w[ADDR_W-2:0], mbits[i][0]};
            exp_q.push_back(w);
            mbits.delete();
        end else begin
            fe_exp++;
            mbits.delete();
        end
    endtask

    // Monitor: chooses addr_ready for the coming edge, then scores the handshake.
    always @(negedge clk) begin
        case (ready_mode)
            0:       addr_ready = 1'b1;
            1:       addr_ready = 1'b0;
            default: addr_ready = ($urandom_range(0, 3) != 0);
        endcase
        if (prev_hold && addr_valid === 1'b1)
            check("addr_stable", addr, prev_addr);
        if (addr_valid === 1'b1) valid_cycles++;
        if (addr_valid === 1'b1 && addr_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word: got %0h, expected no word", addr);
            end else begin
                check("addr", addr, exp_q.pop_front());
            end
        end
        prev_hold = (addr_valid === 1'b1) && !addr_ready;
        prev_addr = addr;
        if (frame_err === 1'b1) fe_seen++;
        if (senack === 1'b1 && senack_d !== 1'b1) ack_pulses++;
        senack_d = senack;
    end

    task automatic wait_senack(input logic lvl, input string name, output int n);
        n = 0;
        while (senack !== lvl && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (senack !== lvl) check(name, senack, lvl);
    endtask

    task automatic send_sym(input logic [1:0] s, output int lat);
        int n;
        wait_senack(1'b0, "ack_low_before", n);
        @(negedge clk);
        bit1 = s[1];
        bit0 = s[0];
        Dt   = 1'b1;
        model_sym(s);
        wait_senack(1'b1, "ack_rise", lat);
        @(negedge clk);
        Dt   = 1'b0;
        bit1 = 1'b0;
        bit0 = 1'b0;
        wait_senack(1'b0, "ack_fall", n);
    endtask

    task automatic send_bits(input logic [ADDR_W-1:0] w, input int nbits);
        int lat;
        for (int i = ADDR_W - 1; i >= ADDR_W - nbits; i--)
            send_sym(w[i] ? 2'b10 : 2'b01, lat);
    endtask

    task automatic send_word(input logic [ADDR_W-1:0] w);
        int lat;
        send_bits(w, ADDR_W);
        send_sym(2'b11, lat);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int lat;
        int n;
        int base_acks;
        logic saw_drop;
        logic [ADDR_W-1:0] w;
        int kind;

        reset = 1'b0;
        bit0  = 1'b0;
        bit1  = 1'b0;
        Dt    = 1'b0;
        addr_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_senack", senack, 0);
        check("rst_valid", addr_valid, 0);
        check("rst_addr", addr, 0);
        check("rst_frame_err", frame_err, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Basic word, consumer always ready; also measure Dt-to-senack latency.
        ack_pulses   = 0;
        valid_cycles = 0;
        send_sym(2'b10, lat);
        check("ack_latency", lat, SYNC_FF + 3);
        send_bits(8'h32, 7);
        send_sym(2'b11, lat);
        drain("b2_drain");
        check("b2_ack_pulses", ack_pulses, 9);
        check("b2_valid_cycles", valid_cycles, 1);
        check("b2_frame_err", fe_seen, fe_exp);

        // Back-pressure: second word's EOW is withheld while the slot is full.
        ready_mode = 1;
        base_acks  = ack_pulses;
        send_word(8'hB2);
        send_bits(8'hB2, 8);
        wait_senack(1'b0, "stall_pre", n);
        @(negedge clk);
        bit1 = 1'b1;
        bit0 = 1'b1;
        Dt   = 1'b1;
        model_sym(2'b11);
        repeat (50) @(negedge clk);
        check("stall_senack", senack, 0);
        check("stall_valid", addr_valid, 1);
        check("stall_addr", addr, 8'hB2);
        ready_mode = 0;
        wait_senack(1'b1, "stall_ack", n);
        @(negedge clk);
        Dt   = 1'b0;
        bit1 = 1'b0;
        bit0 = 1'b0;
        wait_senack(1'b0, "stall_fall", n);
        drain("stall_drain");
        check("stall_ack_pulses", ack_pulses - base_acks, 18);

        // Early EOW, then a clean word.
        send_bits(8'hE0, 3);
        send_sym(2'b11, lat);
        send_word(8'h5A);
        drain("early_eow_drain");
        check("early_eow_frame_err", fe_seen, fe_exp);

        // Illegal symbol mid-word still completes the handshake.
        base_acks = ack_pulses;
        send_bits(8'hF0, 4);
        send_sym(2'b00, lat);
        check("illegal_acks", ack_pulses - base_acks, 5);
        send_word(8'h96);
        drain("illegal_drain");
        check("illegal_frame_err", fe_seen, fe_exp);

        // Dt stuck high: EOW on empty word errors, W_LOW times out, the still-high
        // strobe is then taken as a fresh EOW which errors again.
        wait_senack(1'b0, "tmo_pre", n);
        @(negedge clk);
        bit1 = 1'b1;
        bit0 = 1'b1;
        Dt   = 1'b1;
        model_sym(2'b11);
        fe_exp++;
        model_sym(2'b11);
        saw_drop = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i > 10 && senack === 1'b0) saw_drop = 1'b1;
        end
        check("tmo_senack_dropped", saw_drop, 1);
        Dt   = 1'b0;
        bit1 = 1'b0;
        bit0 = 1'b0;
        wait_senack(1'b0, "tmo_fall", n);
        repeat (4) @(negedge clk);
        check("tmo_idle_senack", senack, 0);
        check("tmo_frame_err", fe_seen, fe_exp);
        send_word(8'hC3);
        drain("tmo_drain");

        // Reset mid-word with a pending word in the slot.
        ready_mode = 1;
        send_word(8'h3C);
        send_bits(8'hA0, 4);
        wait_senack(1'b0, "rst_mid_pre", n);
        @(negedge clk);
        bit1 = 1'b1;
        bit0 = 1'b0;
        Dt   = 1'b1;
        wait_senack(1'b1, "rst_mid_ack", n);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_senack", senack, 0);
        check("rst_mid_valid", addr_valid, 0);
        check("rst_mid_addr", addr, 0);
        @(negedge clk);
        Dt    = 1'b0;
        bit1  = 1'b0;
        bit0  = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        mbits.delete();
        ready_mode = 0;
        repeat (4) @(negedge clk);
        send_word(8'hE7);
        drain("rst_mid_drain");

        // Randomised words with occasional framing faults and random back-pressure.
        ready_mode = 2;
        for (int k = 0; k < 40; k++) begin
            w    = ADDR_W'($urandom);
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                send_bits(w, $urandom_range(1, ADDR_W - 1));
                send_sym(2'b11, lat);
            end else if (kind == 1) begin
                send_bits(w, $urandom_range(1, ADDR_W - 1));
                send_sym(2'b00, lat);
            end else if (kind == 2) begin
                send_bits(w, ADDR_W);
                send_sym(2'b10, lat);
                send_sym(2'b11, lat);
            end else begin
                send_word(w);
            end
        end
        drain("rand_drain");
        check("rand_frame_err", fe_seen, fe_exp);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
